// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//   Instruction fetch responder. It takes the control unit's fetch strobes,
//   owns the program counter, and drives a synchronous instruction memory.
//   It returns the instruction register (ir) and an operand register (dr).
//   dr holds the immediate for LOADIM or the target for JUMPNZ.
//   Every strobe is rising-edge qualified, so a level held high for several
//   cycles causes only one action.
//
//   Ports
//     clk          rising-edge clock
//     reset_n      asynchronous active-low reset
//     imem_read    read strobe (level, edge-detected)
//     pc_inc       PC increment strobe (level, edge-detected)
//     jump         jump strobe (level, edge-detected)
//     z_flag       ALU zero flag, sampled on the jump edge
//     imem_en      memory read enable, one-cycle pulse
//     imem_addr    memory address, latched from pc on the read edge
//     imem_rdata   memory data, valid the cycle after imem_en
//     ir / dr      instruction / operand registers
//     pc           current program counter
//     busy         read outstanding
//     halt         END fetched (or PC overflow when bounds checking is on)
//
//   Configuration
//     IFETCH_BOUNDS_EN  When defined, a pc_inc or a not-taken jump at the
//                       last address holds pc and halts instead of wrapping.
// -----------------------------------------------------------------------------
module ifetch_unit #(
  parameter int BUS_WIDTH  = 16,
  parameter int PC_WIDTH   = 8,
  parameter int OPCODE_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 imem_read,
  input  logic                 pc_inc,
  input  logic                 jump,
  input  logic                 z_flag,
  output logic                 imem_en,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  output logic [BUS_WIDTH-1:0] ir,
  output logic [BUS_WIDTH-1:0] dr,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 busy,
  output logic                 halt
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_HALT} state_t;
  typedef enum logic       {SLOT_INSTR, SLOT_OPERAND}    slot_t;

  localparam logic [OPCODE_LEN-1:0] OP_LOADIM = OPCODE_LEN'(4'h2);
  localparam logic [OPCODE_LEN-1:0] OP_JUMPNZ = OPCODE_LEN'(4'hB);
  localparam logic [OPCODE_LEN-1:0] OP_END    = OPCODE_LEN'(4'hF);

  state_t                r_state;
  state_t                w_state_nxt;
  slot_t                 r_slot;
  logic                  r_read_q, r_inc_q, r_jump_q;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   r_addr;
  logic [BUS_WIDTH-1:0]  r_ir, r_dr;

  logic                  w_read_edge, w_inc_edge, w_jump_edge;
  logic                  w_jump_taken, w_pc_adv, w_pc_ovf;
  logic [OPCODE_LEN-1:0] w_opcode;

  assign w_read_edge = imem_read & ~r_read_q;
  assign w_inc_edge  = pc_inc    & ~r_inc_q;
  assign w_jump_edge = jump      & ~r_jump_q;

  // A jump edge overrides a coincident pc_inc edge. A jump with z_flag set
  // skips the operand word, so it advances pc exactly like an increment.
  assign w_jump_taken = w_jump_edge & ~z_flag;
  assign w_pc_adv     = w_jump_edge ? z_flag : w_inc_edge;

`ifdef IFETCH_BOUNDS_EN
  assign w_pc_ovf = w_pc_adv & (r_pc == {PC_WIDTH{1'b1}});
`else
  assign w_pc_ovf = 1'b0;
`endif

  assign w_opcode = imem_rdata[BUS_WIDTH-1 -: OPCODE_LEN];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: state elements use non-blocking assignments, so every flop in
      // the same edge sees the pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: the default assignment ahead of the case keeps every path
    // assigned, so no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_read_edge) w_state_nxt = S_RD;
      S_RD:    w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = (r_slot == SLOT_INSTR && w_opcode == OP_END) ? S_HALT : S_IDLE;
      default: w_state_nxt = S_HALT;
    endcase
    if (w_pc_ovf && r_state != S_HALT) w_state_nxt = S_HALT;
  end

  // Output logic
  always_comb begin
    imem_en = (r_state == S_RD);
    busy    = (r_state == S_RD) || (r_state == S_CAP);
    halt    = (r_state == S_HALT);
  end

  // Datapath: edge history, PC, address latch, ir/dr capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_q <= 1'b0;
      r_inc_q  <= 1'b0;
      r_jump_q <= 1'b0;
      r_pc     <= '0;
      r_addr   <= '0;
      r_ir     <= '0;
      r_dr     <= '0;
      r_slot   <= SLOT_INSTR;
    end else begin
      r_read_q <= imem_read;
      r_inc_q  <= pc_inc;
      r_jump_q <= jump;

      // The address is frozen at the read edge. A pc update in the same
      // cycle or a later one does not move an in-flight read.
      if (r_state == S_IDLE && w_read_edge) r_addr <= r_pc;

      if (r_state == S_CAP) begin
        if (r_slot == SLOT_INSTR) begin
          r_ir   <= imem_rdata;
          r_slot <= (w_opcode == OP_LOADIM || w_opcode == OP_JUMPNZ) ? SLOT_OPERAND : SLOT_INSTR;
        end else begin
          r_dr   <= imem_rdata;
          r_slot <= SLOT_INSTR;
        end
      end

      if (r_state != S_HALT) begin
        if (w_jump_taken)              r_pc <= r_dr[PC_WIDTH-1:0];
        else if (w_pc_adv && !w_pc_ovf) r_pc <= r_pc + PC_WIDTH'(1);
      end
    end
  end

  assign imem_addr = r_addr;
  assign ir        = r_ir;
  assign dr        = r_dr;
  assign pc        = r_pc;

endmodule
